// File: rtl/lfsr_payload_checker.sv
// Receive-side checker for lfsr16 payload bursts: word 0 seeds a local LFSR, later words are compared.
// Optional first-mismatch capture ports are built when LFSR_CHK_FIRST_ERR_EN is defined.
module lfsr_payload_checker #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [15:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             clr_cnt,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] bad_pkt_cnt,
    output logic [CNT_W-1:0] bad_word_cnt
`ifdef LFSR_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_vld,
    output logic [15:0]      first_err_idx,
    output logic [15:0]      first_err_exp,
    output logic [15:0]      first_err_got
`endif
);

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX  = 16'(MAX_WORDS - 1);
    localparam bit          SEED_ONLY = (MAX_WORDS == 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Clear takes effect before the increment, so clear+increment in one cycle yields 1.
    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cur,
                                                 input logic clr, input logic inc);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != '1))
            base = base + 1'b1;
        return base;
    endfunction

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [15:0] r_word_idx;
    logic        r_bad;
    logic        r_ready;
    logic        r_pkt_done;
    logic        r_pkt_ok;

    logic        w_accept;
    logic [15:0] w_expect;
    logic        w_mismatch;
    logic        w_seed_bad;
    logic        w_chk_bad;

    assign w_accept   = s_valid && r_ready;
    assign w_expect   = lfsr_step(r_lfsr);
    assign w_mismatch = w_accept && (r_state == ST_CHECK) && (s_data != w_expect);
    assign w_seed_bad = (s_data == 16'h0000) || (SEED_ONLY && !s_last);
    assign w_chk_bad  = r_bad || (s_data != w_expect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SEED;
            r_lfsr     <= 16'h0001;
            r_word_idx <= '0;
            r_bad      <= 1'b0;
            r_ready    <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_ok   <= 1'b0;
        end else begin
            r_ready    <= 1'b1;
            r_pkt_done <= 1'b0;
            r_pkt_ok   <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_SEED: begin
                        r_lfsr     <= s_data;
                        r_word_idx <= 16'd1;
                        r_bad      <= w_seed_bad;
                        if (s_last) begin
                            r_pkt_done <= 1'b1;
                            r_pkt_ok   <= ~w_seed_bad;
                            r_state    <= ST_SEED;
                        end else if (w_seed_bad) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        // No resync: the local sequence runs on regardless of what arrived.
                        r_lfsr     <= w_expect;
                        r_word_idx <= r_word_idx + 16'd1;
                        if (s_last) begin
                            r_pkt_done <= 1'b1;
                            r_pkt_ok   <= ~w_chk_bad;
                            r_bad      <= w_chk_bad;
                            r_state    <= ST_SEED;
                        end else if (r_word_idx == LAST_IDX) begin
                            r_bad   <= 1'b1;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_bad <= w_chk_bad;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_last) begin
                            r_pkt_done <= 1'b1;
                            r_pkt_ok   <= ~r_bad;
                            r_state    <= ST_SEED;
                        end
                    end
                    default: begin
                        r_state <= ST_SEED;
                    end
                endcase
            end
        end
    end

    assign s_ready  = r_ready;
    assign pkt_done = r_pkt_done;
    assign pkt_ok   = r_pkt_ok;

    // Statistics: 0 = packets, 1 = bad packets, 2 = bad words. Packet counts follow the verdict pulse.
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_cnt_inc;

    assign w_cnt_inc[0] = r_pkt_done;
    assign w_cnt_inc[1] = r_pkt_done && !r_pkt_ok;
    assign w_cnt_inc[2] = w_mismatch;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst)
                    r_cnt[gi] <= '0;
                else
                    r_cnt[gi] <= cnt_upd(r_cnt[gi], clr_cnt, w_cnt_inc[gi]);
            end
        end
    endgenerate

    assign pkt_cnt      = r_cnt[0];
    assign bad_pkt_cnt  = r_cnt[1];
    assign bad_word_cnt = r_cnt[2];

`ifdef LFSR_CHK_FIRST_ERR_EN
    logic        r_fe_vld;
    logic [15:0] r_fe_idx;
    logic [15:0] r_fe_exp;
    logic [15:0] r_fe_got;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fe_vld <= 1'b0;
            r_fe_idx <= '0;
            r_fe_exp <= '0;
            r_fe_got <= '0;
        end else if (w_mismatch && (clr_cnt || !r_fe_vld)) begin
            r_fe_vld <= 1'b1;
            r_fe_idx <= r_word_idx;
            r_fe_exp <= w_expect;
            r_fe_got <= s_data;
        end else if (clr_cnt) begin
            r_fe_vld <= 1'b0;
            r_fe_idx <= '0;
            r_fe_exp <= '0;
            r_fe_got <= '0;
        end
    end

    assign first_err_vld = r_fe_vld;
    assign first_err_idx = r_fe_idx;
    assign first_err_exp = r_fe_exp;
    assign first_err_got = r_fe_got;
`endif

endmodule

// File: tb/tb_lfsr_payload_checker.sv
// Directed bench for lfsr_payload_checker: a default instance plus a MAX_WORDS=4, CNT_W=2 instance
// sharing the same stimulus to exercise the overlong-packet and counter-saturation boundaries.
module tb_lfsr_payload_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        clr_cnt;

    logic        s_ready, pkt_done, pkt_ok;
    logic [31:0] pkt_cnt, bad_pkt_cnt, bad_word_cnt;
    logic        s_ready4, pkt_done4, pkt_ok4;
    logic [1:0]  pkt_cnt4, bad_pkt_cnt4, bad_word_cnt4;
`ifdef LFSR_CHK_FIRST_ERR_EN
    logic        fe_vld, fe_vld4;
    logic [15:0] fe_idx, fe_exp, fe_got, fe_idx4, fe_exp4, fe_got4;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] pq [$];

    always #5 clk = ~clk;

    lfsr_payload_checker #(.MAX_WORDS(1024), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .clr_cnt(clr_cnt), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
        .pkt_cnt(pkt_cnt), .bad_pkt_cnt(bad_pkt_cnt), .bad_word_cnt(bad_word_cnt)
`ifdef LFSR_CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld), .first_err_idx(fe_idx), .first_err_exp(fe_exp), .first_err_got(fe_got)
`endif
    );

    lfsr_payload_checker #(.MAX_WORDS(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready4), .clr_cnt(clr_cnt), .pkt_done(pkt_done4), .pkt_ok(pkt_ok4),
        .pkt_cnt(pkt_cnt4), .bad_pkt_cnt(bad_pkt_cnt4), .bad_word_cnt(bad_word_cnt4)
`ifdef LFSR_CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld4), .first_err_idx(fe_idx4), .first_err_exp(fe_exp4), .first_err_got(fe_got4)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int g;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        g = 0;
        while (!s_ready && g < 16) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready)
            check_val("ready_timeout", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_q();
        foreach (pq[i])
            send_word(pq[i], i == pq.size() - 1);
    endtask

    // Verdict one cycle after the last word, counters settled one cycle after that.
    task automatic finish_pkt(input string name, input logic e_ok, input logic e_ok4,
                              input int e_p, input int e_bp, input int e_bw,
                              input int e_p4, input int e_bp4, input int e_bw4);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_val({name, ".done"},  {31'b0, pkt_done},  32'd1);
        check_val({name, ".ok"},    {31'b0, pkt_ok},    {31'b0, e_ok});
        check_val({name, ".done4"}, {31'b0, pkt_done4}, 32'd1);
        check_val({name, ".ok4"},   {31'b0, pkt_ok4},   {31'b0, e_ok4});
        @(negedge clk);
        check_val({name, ".done_low"}, {31'b0, pkt_done}, 32'd0);
        check_val({name, ".pkt"},   pkt_cnt,      e_p);
        check_val({name, ".bpkt"},  bad_pkt_cnt,  e_bp);
        check_val({name, ".bword"}, bad_word_cnt, e_bw);
        check_val({name, ".pkt4"},  {30'b0, pkt_cnt4},      e_p4);
        check_val({name, ".bpkt4"}, {30'b0, bad_pkt_cnt4},  e_bp4);
        check_val({name, ".bword4"},{30'b0, bad_word_cnt4}, e_bw4);
        $display("pkt %s: ok=%0b ok4=%0b pkt_cnt=%0d bad_pkt=%0d bad_word=%0d",
                 name, pkt_ok, pkt_ok4, pkt_cnt, bad_pkt_cnt, bad_word_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.ready", {31'b0, s_ready},  32'd0);
        check_val("rst.done",  {31'b0, pkt_done}, 32'd0);
        check_val("rst.ok",    {31'b0, pkt_ok},   32'd0);
        check_val("rst.pkt",   pkt_cnt,      32'd0);
        check_val("rst.bword", bad_word_cnt, 32'd0);
        rst = 1'b0;

        pq = {16'h0001, 16'h8000, 16'h4000, 16'h2000};
        send_q();
        finish_pkt("t1_clean", 1'b1, 1'b1, 1, 0, 0, 1, 0, 0);

        pq = {16'h0001, 16'h8000, 16'h4001, 16'h2000};
        send_q();
        finish_pkt("t2_badword", 1'b0, 1'b0, 2, 1, 1, 2, 1, 1);
`ifdef LFSR_CHK_FIRST_ERR_EN
        check_val("t2.fe_vld", {31'b0, fe_vld}, 32'd1);
        check_val("t2.fe_idx", {16'b0, fe_idx}, 32'd2);
        check_val("t2.fe_exp", {16'b0, fe_exp}, 32'h4000);
        check_val("t2.fe_got", {16'b0, fe_got}, 32'h4001);
`endif

        pq = {16'h0001, 16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400,
              16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h8010};
        send_q();
        finish_pkt("t3_tap5", 1'b1, 1'b0, 3, 1, 1, 3, 2, 1);

        pq = {16'h0000, 16'h1234, 16'h5678};
        send_q();
        finish_pkt("t4_seed0", 1'b0, 1'b0, 4, 2, 1, 3, 3, 1);

        pq = {16'h0001, 16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800};
        send_q();
        finish_pkt("t4_long6", 1'b1, 1'b0, 5, 2, 1, 3, 3, 1);

        pq = {16'h0001, 16'h8001};
        send_q();
        finish_pkt("lastbad", 1'b0, 1'b0, 6, 3, 2, 3, 3, 2);

        pq = {16'h1234};
        send_q();
        finish_pkt("seedonly", 1'b1, 1'b1, 7, 3, 2, 3, 3, 2);

        // Back-to-back packets with a counter clear on the first verdict cycle.
        send_word(16'h0001, 1'b0);
        send_word(16'h8000, 1'b1);
        @(negedge clk);
        check_val("t5.doneA", {31'b0, pkt_done}, 32'd1);
        check_val("t5.okA",   {31'b0, pkt_ok},   32'd1);
        clr_cnt = 1'b1;
        s_valid = 1'b1; s_data = 16'hACE1; s_last = 1'b0;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check_val("t5.pkt_after_clr",  pkt_cnt,      32'd1);
        check_val("t5.bpkt_after_clr", bad_pkt_cnt,  32'd0);
        check_val("t5.bword_after_clr",bad_word_cnt, 32'd0);
        check_val("t5.pkt4_after_clr", {30'b0, pkt_cnt4}, 32'd1);
        $display("pkt t5_A: pkt_cnt=%0d after clear", pkt_cnt);
        send_word(16'h5670, 1'b0);
        send_word(16'hAB38, 1'b1);
        finish_pkt("t5_B", 1'b1, 1'b1, 2, 0, 0, 2, 0, 0);
`ifdef LFSR_CHK_FIRST_ERR_EN
        check_val("t5.fe_vld", {31'b0, fe_vld}, 32'd0);
`endif

        // Reset in the middle of a packet.
        send_word(16'h0001, 1'b0);
        send_word(16'h8000, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6.rst_ready", {31'b0, s_ready},  32'd0);
        check_val("t6.rst_done",  {31'b0, pkt_done}, 32'd0);
        check_val("t6.rst_pkt",   pkt_cnt,           32'd0);
        rst = 1'b0;
        send_word(16'h0001, 1'b0);
        send_word(16'h8000, 1'b1);
        finish_pkt("t6_after_rst", 1'b1, 1'b1, 1, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
